// File: rtl/tdm_pkg.sv
// TDM receive shared types: FSM encoding, default sizing, slice helper.
package tdm_pkg;

  localparam int TDM_WIDTH    = 4;
  localparam int TDM_CHANNELS = 4;
  localparam int TDM_SEL_W    = 2;
  localparam int MAX_BUS      = 256;
  localparam int MAX_W        = 32;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_e;

  // Caller truncates the result to its own channel width.
  function automatic logic [MAX_W-1:0] chan_slice(
    input logic [MAX_BUS-1:0] bus,
    input int                 idx,
    input int                 w
  );
    logic [MAX_BUS-1:0] sh;
    sh = bus >> (idx * w);
    return sh[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/tdm_demux_rx_if.sv
// Muxed link beat bundle: data, beat valid, slot-0 sync flag.
interface tdm_demux_rx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_sync;

  modport master (
    output din,
    output din_valid,
    output frame_sync
  );

  modport slave (
    input din,
    input din_valid,
    input frame_sync
  );
endinterface

// File: rtl/tdm_slot_counter.sv
// Slot index counter for the TDM receiver.
module tdm_slot_counter #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_load1,
  input  logic             i_clr,
  output logic [SEL_W-1:0] o_slot,
  output logic             o_last,
  output logic             o_wrap
);

  logic [SEL_W-1:0] r_slot;
  logic             w_last;

  assign w_last = (r_slot == SEL_W'(CHANNELS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
    end else if (i_clr) begin
      r_slot <= '0;
    end else if (i_load1) begin
      r_slot <= SEL_W'(1);
    end else if (i_inc) begin
      r_slot <= w_last ? '0 : r_slot + 1'b1;
    end
  end

  assign o_slot = r_slot;
  assign o_last = w_last;
  assign o_wrap = i_inc & w_last;

endmodule

// File: rtl/tdm_demux_rx.sv
// TDM receiver: realigns slot beats into a double-buffered parallel frame.
module tdm_demux_rx
  import tdm_pkg::*;
#(
  parameter int WIDTH    = TDM_WIDTH,
  parameter int CHANNELS = TDM_CHANNELS,
  parameter int SEL_W    = TDM_SEL_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  tdm_demux_rx_if.slave             bus,
  input  logic [SEL_W-1:0]          led_sel,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic                      frame_done,
  output logic                      frame_err,
  output logic [WIDTH-1:0]          LED
);

  tdm_state_e r_state, w_next;

  logic [WIDTH-1:0]          r_stage [CHANNELS-1];
  logic [CHANNELS*WIDTH-1:0] r_dout;
  logic                      r_done;
  logic                      r_err;

  logic [SEL_W-1:0]          w_slot;
  logic                      w_last;
  logic                      w_wrap;
  logic                      w_slot0;
  logic                      w_inc;
  logic                      w_load1;
  logic                      w_clr;
  logic                      w_wr;
  logic [SEL_W-1:0]          w_wr_idx;
  logic                      w_err;
  logic [CHANNELS*WIDTH-1:0] w_frame;

  tdm_slot_counter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_inc),
    .i_load1 (w_load1),
    .i_clr   (w_clr),
    .o_slot  (w_slot),
    .o_last  (w_last),
    .o_wrap  (w_wrap)
  );

  assign w_slot0 = (w_slot == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= HUNT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_inc    = 1'b0;
    w_load1  = 1'b0;
    w_clr    = 1'b0;
    w_wr     = 1'b0;
    w_wr_idx = w_slot;
    w_err    = 1'b0;
    if (bus.din_valid) begin
      unique case (r_state)
        HUNT: begin
          if (bus.frame_sync) begin
            w_wr     = 1'b1;
            w_wr_idx = '0;
            w_load1  = 1'b1;
            w_next   = RUN;
          end
        end
        RUN: begin
          unique case (1'b1)
            bus.frame_sync && !w_slot0: begin
              w_err    = 1'b1;
              w_wr     = 1'b1;
              w_wr_idx = '0;
              w_load1  = 1'b1;
            end
            bus.frame_sync && w_slot0: begin
              w_wr     = 1'b1;
              w_wr_idx = '0;
              w_load1  = 1'b1;
            end
            !bus.frame_sync && w_slot0: begin
              w_err  = 1'b1;
              w_clr  = 1'b1;
              w_next = HUNT;
            end
            default: begin
              w_inc = 1'b1;
              w_wr  = !w_last;
            end
          endcase
        end
        default: w_next = HUNT;
      endcase
    end
  end

  // Last beat goes straight into the output frame, never staged.
  always_comb begin
    w_frame = '0;
    for (int k = 0; k < CHANNELS - 1; k++) begin
      w_frame[k*WIDTH +: WIDTH] = r_stage[k];
    end
    w_frame[(CHANNELS-1)*WIDTH +: WIDTH] = bus.din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS - 1; k++) begin
        r_stage[k] <= '0;
      end
    end else if (w_wr) begin
      r_stage[w_wr_idx] <= bus.din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_wrap;
      r_err  <= w_err;
      if (w_wrap) r_dout <= w_frame;
    end
  end

  assign dout       = r_dout;
  assign frame_done = r_done;
  assign frame_err  = r_err;

  assign LED = (int'(led_sel) < CHANNELS)
             ? WIDTH'(chan_slice(MAX_BUS'(r_dout), int'(led_sel), WIDTH))
             : '0;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Directed bench for tdm_demux_rx with hand-computed frames.
module tb_tdm_demux_rx;

  logic        clk;
  logic        rst_n;
  logic [1:0]  led_sel;
  logic [15:0] dout;
  logic        frame_done;
  logic        frame_err;
  logic [3:0]  LED;

  int n_chk;
  int n_err;

  tdm_demux_rx_if #(.WIDTH(4)) bus ();

  tdm_demux_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .led_sel    (led_sel),
    .dout       (dout),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .LED        (LED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [3:0] d, input logic s);
    bus.din        = d;
    bus.din_valid  = 1'b1;
    bus.frame_sync = s;
    @(posedge clk);
    #1;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
  endtask

  task automatic idle();
    bus.din_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("gap_done", 32'(frame_done), 32'd0);
    chk("gap_err", 32'(frame_err), 32'd0);
  endtask

  initial begin
    logic [15:0] exp;
    logic [3:0]  v;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    led_sel = 2'd2;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.frame_sync = 1'b0;
    #1;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_led", 32'(LED), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // unsynced beat in HUNT is dropped silently
    beat(4'h7, 1'b0);
    chk("hunt_drop_err", 32'(frame_err), 32'd0);
    chk("hunt_drop_done", 32'(frame_done), 32'd0);

    beat(4'h1, 1'b1);
    beat(4'h2, 1'b0);
    beat(4'h3, 1'b0);
    chk("f1_no_early_done", 32'(frame_done), 32'd0);
    chk("f1_dout_hold", 32'(dout), 32'h0);
    beat(4'h4, 1'b0);
    chk("f1_done", 32'(frame_done), 32'd1);
    chk("f1_dout", 32'(dout), 32'h4321);
    chk("f1_led2", 32'(LED), 32'h3);

    beat(4'hD, 1'b1);
    chk("gap_done_clear", 32'(frame_done), 32'd0);
    idle();
    beat(4'hC, 1'b0);
    idle();
    idle();
    beat(4'hB, 1'b0);
    idle();
    chk("gap_dout_hold", 32'(dout), 32'h4321);
    beat(4'hA, 1'b0);
    chk("gap_done", 32'(frame_done), 32'd1);
    chk("gap_dout", 32'(dout), 32'hABCD);
    chk("gap_led2", 32'(LED), 32'hB);

    beat(4'hA, 1'b1);
    beat(4'hB, 1'b0);
    beat(4'h5, 1'b1);
    chk("early_err", 32'(frame_err), 32'd1);
    chk("early_no_done", 32'(frame_done), 32'd0);
    chk("early_dout_hold", 32'(dout), 32'hABCD);
    beat(4'h6, 1'b0);
    chk("early_err_clear", 32'(frame_err), 32'd0);
    beat(4'h7, 1'b0);
    beat(4'h8, 1'b0);
    chk("early_done", 32'(frame_done), 32'd1);
    chk("early_dout", 32'(dout), 32'h8765);

    beat(4'h9, 1'b0);
    chk("miss_err", 32'(frame_err), 32'd1);
    chk("miss_dout_hold", 32'(dout), 32'h8765);
    beat(4'h1, 1'b0);
    chk("miss_hunt_no_err", 32'(frame_err), 32'd0);
    beat(4'hE, 1'b1);
    beat(4'hF, 1'b0);
    beat(4'h0, 1'b0);
    beat(4'h1, 1'b0);
    chk("resync_done", 32'(frame_done), 32'd1);
    chk("resync_dout", 32'(dout), 32'h10FE);

    // three back-to-back frames, valid never drops at an edge
    for (int f = 0; f < 3; f++) begin
      exp = '0;
      for (int k = 0; k < 4; k++) begin
        v = 4'(8 + f * 4 + k);
        exp[k*4 +: 4] = v;
        beat(v, k == 0);
        chk($sformatf("strm_done_f%0d_k%0d", f, k),
            32'(frame_done), 32'(k == 3));
      end
      chk($sformatf("strm_dout_f%0d", f), 32'(dout), 32'(exp));
    end
    chk("strm_dout_last", 32'(dout), 32'h3210);

    led_sel = 2'd3;
    #1;
    chk("led3", 32'(LED), 32'h3);
    beat(4'h5, 1'b1);
    beat(4'h6, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_dout", 32'(dout), 32'h0);
    chk("arst_led", 32'(LED), 32'h0);
    chk("arst_done", 32'(frame_done), 32'd0);
    chk("arst_err", 32'(frame_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    beat(4'h5, 1'b0);
    chk("post_rst_drop_err", 32'(frame_err), 32'd0);
    beat(4'h1, 1'b1);
    beat(4'h2, 1'b0);
    beat(4'h3, 1'b0);
    chk("post_rst_no_done", 32'(frame_done), 32'd0);
    beat(4'h4, 1'b0);
    chk("post_rst_done", 32'(frame_done), 32'd1);
    chk("post_rst_dout", 32'(dout), 32'h4321);
    chk("post_rst_led3", 32'(LED), 32'h4);
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
